// File: rtl/rx_deframer_pkg.sv
// rx_deframer_pkg: shared types and constants for the receive deframer.
package rx_deframer_pkg;

    // Default frame sync pattern, most significant byte arrives first.
    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5C3_5A3C;

    typedef enum logic [1:0] {
        StHunt,
        StLenHi,
        StLenLo,
        StPayload
    } state_e;

    // One payload word plus its frame-boundary markers.
    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } frame_word_t;

endpackage

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: synchronous FIFO of frame words, asynchronous active-high reset.
// A write while full is accepted only when a read happens in the same cycle.
module rx_word_fifo
    import rx_deframer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  frame_word_t wr_data_i,
    input  logic        rd_en_i,
    output frame_word_t rd_data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    frame_word_t mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        wr_ok;
    logic        rd_ok;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_ok     = wr_en_i && (!full_o || rd_en_i);
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array, no reset needed since empty_o masks stale entries.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// rx_deframer: hunts for a 32-bit sync word on a byte stream, reads a 16-bit
// big-endian word count, then packs payload bytes little-endian into 32-bit
// words delivered downstream through a small FIFO.
// Build macro RX_DEFRAMER_STATS_EN adds saturating frame/drop counters.
module rx_deframer
    import rx_deframer_pkg::*;
#(
    parameter logic [31:0] C_SYNC_WORD  = SYNC_WORD_DEFAULT,
    parameter int unsigned C_MAX_LEN    = 256,
    parameter int unsigned C_FIFO_DEPTH = 4
) (
    input  logic        i_aclk,
    input  logic        i_areset,
    input  logic        i_enable,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_sof,
    output logic        m_axis_eof,
    output logic        o_overflow,
`ifdef RX_DEFRAMER_STATS_EN
    output logic [31:0] o_frame_count,
    output logic [15:0] o_drop_count,
`endif
    output logic        o_len_error
);

    state_e      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] acc_q, acc_d;
    logic        push_q, push_d;
    frame_word_t word_q, word_d;
    logic        overflow_q, overflow_d;
    logic        len_error_q, len_error_d;

    logic [31:0] shift_next;
    logic [15:0] len_full;
    logic        fifo_full;
    logic        fifo_empty;
    frame_word_t fifo_head;
    logic        pop;
    logic        word_drop;
    logic        fifo_wr;

    assign shift_next = {shift_q[23:0], i_byte_data};
    assign len_full   = {len_q[15:8], i_byte_data};
    assign pop        = m_axis_tvalid && m_axis_tready;
    // A full FIFO still takes the word if the head leaves in the same cycle.
    assign word_drop  = push_q && fifo_full && !pop;
    assign fifo_wr    = push_q && !word_drop;

    // Next-state logic: sync hunt, length capture, payload packing, abort on drop.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        acc_d       = acc_q;
        push_d      = 1'b0;
        word_d      = word_q;
        overflow_d  = overflow_q;
        len_error_d = len_error_q;

        unique case (state_q)
            StHunt: begin
                if (i_byte_valid) begin
                    shift_d = shift_next;
                    if (i_enable && (shift_next == C_SYNC_WORD)) begin
                        state_d = StLenHi;
                        // Cleared so the next hunt needs four fresh bytes.
                        shift_d = '0;
                    end
                end
            end
            StLenHi: begin
                if (i_byte_valid) begin
                    len_d[15:8] = i_byte_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (i_byte_valid) begin
                    if ((len_full == 16'd0) || (32'(len_full) > C_MAX_LEN)) begin
                        len_error_d = 1'b1;
                        state_d     = StHunt;
                    end else begin
                        len_d      = len_full;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        state_d    = StPayload;
                    end
                end
            end
            StPayload: begin
                if (i_byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: acc_d[7:0]   = i_byte_data;
                        2'd1: acc_d[15:8]  = i_byte_data;
                        2'd2: acc_d[23:16] = i_byte_data;
                        default: begin
                            push_d      = 1'b1;
                            word_d.data = {i_byte_data, acc_q};
                            word_d.sof  = (word_cnt_q == 16'd0);
                            word_d.eof  = (word_cnt_q == len_q - 16'd1);
                            word_cnt_d  = word_cnt_q + 16'd1;
                            if (word_cnt_q == len_q - 16'd1) begin
                                state_d = StHunt;
                            end
                        end
                    endcase
                end
            end
            default: state_d = StHunt;
        endcase

        if (word_drop) begin
            overflow_d = 1'b1;
            state_d    = StHunt;
            shift_d    = '0;
            push_d     = 1'b0;
        end
    end

    // Deframer state and staged output word.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q     <= StHunt;
            shift_q     <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            acc_q       <= '0;
            push_q      <= 1'b0;
            word_q      <= '0;
            overflow_q  <= 1'b0;
            len_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            push_q      <= push_d;
            word_q      <= word_d;
            overflow_q  <= overflow_d;
            len_error_q <= len_error_d;
        end
    end

    rx_word_fifo #(
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_aclk),
        .rst_i     (i_areset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (word_q),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Head fields are masked while empty so idle outputs read as zero.
    always_comb begin
        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = fifo_empty ? 32'd0 : fifo_head.data;
        m_axis_sof    = !fifo_empty && fifo_head.sof;
        m_axis_eof    = !fifo_empty && fifo_head.eof;
    end

    assign o_overflow  = overflow_q;
    assign o_len_error = len_error_q;

`ifdef RX_DEFRAMER_STATS_EN
    logic [31:0] frame_count_q;
    logic [15:0] drop_count_q;

    // Saturating counters: eof words taken downstream, frames aborted by overflow.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if (pop && fifo_head.eof && (frame_count_q != '1)) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
            if (word_drop && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign o_frame_count = frame_count_q;
    assign o_drop_count  = drop_count_q;
`endif

endmodule
